// File: rtl/srlatch_arbiter.sv
// Round-robin arbiter sharing one external SR latch between NREQ requesters.
// Each grant drives a timed S or R pulse, waits for settling, reads Q back and acknowledges.
module srlatch_arbiter #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned PULSE_CYC  = 2,
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [NREQ-1:0] REQ,
    input  logic [NREQ-1:0] OP,
    output logic [NREQ-1:0] GNT,
    output logic [NREQ-1:0] ACK,
    output logic            ERR,
    output logic            BUSY,
    output logic            S_OUT,
    output logic            R_OUT,
    input  logic            Q_IN
);

    localparam int unsigned CNT_MAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned IW      = $clog2(NREQ);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            target_q, target_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            s_q, s_d;
    logic            r_q, r_d;

    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [NREQ-1:0] win_oh;
    logic            win_tgt;
    logic            win_skip;
    logic            cnt_last;
    int unsigned     scan_k;

    // Round-robin scan starting at ptr_q, wrapping modulo NREQ
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_k    = 0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            scan_k = (32'(ptr_q) + off) % NREQ;
            if (!win_found && REQ[IW'(scan_k)]) begin
                win_found = 1'b1;
                win_idx   = IW'(scan_k);
            end
        end
    end

    assign win_oh   = NREQ'(1) << win_idx;
    assign win_tgt  = OP[win_idx];
    assign win_skip = (Q_IN == win_tgt);
    assign cnt_last = (cnt_q == CW'(1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            target_q <= 1'b0;
            gnt_q    <= '0;
            ack_q    <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            s_q      <= 1'b0;
            r_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            gnt_q    <= gnt_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            s_q      <= s_d;
            r_q      <= r_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = win_skip ? ST_DONE : ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (cnt_last) begin
                    state_d = (SETTLE_CYC > 0) ? ST_SETTLE : ST_CHECK;
                end
            end
            ST_SETTLE: begin
                if (cnt_last) begin
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Registered outputs and datapath; drives are only ever raised one at a time
    always_comb begin
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        gnt_d    = gnt_q;
        ack_d    = '0;
        err_d    = 1'b0;
        s_d      = 1'b0;
        r_d      = 1'b0;
        busy_d   = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    gnt_d    = win_oh;
                    target_d = win_tgt;
                    ptr_d    = IW'((32'(win_idx) + 1) % NREQ);
                    if (win_skip) begin
                        ack_d = win_oh;
                    end else begin
                        s_d   = win_tgt;
                        r_d   = !win_tgt;
                        cnt_d = CW'(PULSE_CYC);
                    end
                end
            end
            ST_DRIVE: begin
                if (cnt_last) begin
                    cnt_d = CW'(SETTLE_CYC);
                end else begin
                    s_d   = s_q;
                    r_d   = r_q;
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_SETTLE: begin
                if (!cnt_last) begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_CHECK: begin
                ack_d = gnt_q;
                err_d = (Q_IN != target_q);
            end
            ST_DONE: begin
                gnt_d = '0;
            end
            default: begin
                gnt_d = '0;
            end
        endcase
    end

    assign GNT   = gnt_q;
    assign ACK   = ack_q;
    assign ERR   = err_q;
    assign BUSY  = busy_q;
    assign S_OUT = s_q;
    assign R_OUT = r_q;

endmodule

// File: tb/tb_srlatch_arbiter.sv
// Bench for srlatch_arbiter: default-timing instance plus a PULSE_CYC=1/SETTLE_CYC=0 instance,
// each driving an ideal external SR latch model (1-cycle delay) with an optional stuck-at-0 Q.
module tb_srlatch_arbiter;

    logic       CLK;
    logic       RST;
    logic [3:0] req_a, op_a, gnt_a, ack_a;
    logic [3:0] req_b, op_b, gnt_b, ack_b;
    logic       err_a, busy_a, s_a, r_a, q_a;
    logic       err_b, busy_b, s_b, r_b, q_b;

    logic       lq [2];
    logic [1:0] pre_en;
    logic [1:0] pre_val;
    logic [1:0] stuck;
    bit         cur;

    logic [3:0] gnt_o, ack_o;
    logic       err_o, busy_o, s_o, r_o;

    int n_cmp   = 0;
    int n_err   = 0;
    int ovl_cnt = 0;
    int m_ptr [2];

    typedef struct {
        bit         sel;
        logic [3:0] req;
        logic [3:0] op;
        bit         pre;
        bit         pre_val;
        bit         stuck;
        bit         drop;
        int         exp_w;
        int         exp_lat;
        bit         exp_err;
    } vec_t;

    vec_t tbl [12];

    srlatch_arbiter #(.NREQ(4), .PULSE_CYC(2), .SETTLE_CYC(1)) u_a (
        .CLK(CLK), .RST(RST), .REQ(req_a), .OP(op_a), .GNT(gnt_a), .ACK(ack_a),
        .ERR(err_a), .BUSY(busy_a), .S_OUT(s_a), .R_OUT(r_a), .Q_IN(q_a)
    );

    srlatch_arbiter #(.NREQ(4), .PULSE_CYC(1), .SETTLE_CYC(0)) u_b (
        .CLK(CLK), .RST(RST), .REQ(req_b), .OP(op_b), .GNT(gnt_b), .ACK(ack_b),
        .ERR(err_b), .BUSY(busy_b), .S_OUT(s_b), .R_OUT(r_b), .Q_IN(q_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    assign q_a    = stuck[0] ? 1'b0 : lq[0];
    assign q_b    = stuck[1] ? 1'b0 : lq[1];
    assign gnt_o  = cur ? gnt_b  : gnt_a;
    assign ack_o  = cur ? ack_b  : ack_a;
    assign err_o  = cur ? err_b  : err_a;
    assign busy_o = cur ? busy_b : busy_a;
    assign s_o    = cur ? s_b    : s_a;
    assign r_o    = cur ? r_b    : r_a;

    // Ideal external latch: follows S/R one edge later, optionally preset by the bench
    always @(posedge CLK) begin
        if (pre_en[0]) lq[0] <= pre_val[0];
        else if (s_a)  lq[0] <= 1'b1;
        else if (r_a)  lq[0] <= 1'b0;
        if (pre_en[1]) lq[1] <= pre_val[1];
        else if (s_b)  lq[1] <= 1'b1;
        else if (r_b)  lq[1] <= 1'b0;
    end

    always @(posedge CLK or negedge CLK or posedge RST or negedge RST) begin
        assert (!(s_a && r_a) && !(s_b && r_b)) else ovl_cnt <= ovl_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic preset(input bit sel, input bit v);
        pre_en[sel]  = 1'b1;
        pre_val[sel] = v;
        @(posedge CLK); #1;
        pre_en[sel]  = 1'b0;
        @(negedge CLK);
    endtask

    // One transaction from IDLE; expectations come from the arbitration/latch rules directly
    task automatic run_op(input bit sel, input logic [3:0] req, input logic [3:0] op,
                          input bit stk, input bit drop,
                          output int act_w, output int act_lat, output logic act_err);
        int         p, s, w, lat_exp, s_cnt, r_cnt;
        bit         tgt, q0, qf, skip, err_exp;
        logic [3:0] w_oh, rv;
        p   = sel ? 1 : 2;
        s   = sel ? 0 : 1;
        cur = sel;
        stuck[sel] = stk;
        rv  = req;
        w   = -1;
        for (int k = 0; k < 4; k++) begin
            if (w < 0 && rv[2'((m_ptr[sel] + k) % 4)]) w = (m_ptr[sel] + k) % 4;
        end
        w_oh       = 4'b0001 << w;
        m_ptr[sel] = (w + 1) % 4;
        tgt     = op[2'(w)];
        q0      = stk ? 1'b0 : lq[sel];
        skip    = (q0 == tgt);
        qf      = stk ? 1'b0 : tgt;
        err_exp = !skip && (qf != tgt);
        lat_exp = skip ? 0 : p + s + 1;
        if (sel) begin req_b = req; op_b = op; end
        else     begin req_a = req; op_a = op; end
        act_w = -1; act_lat = -1; act_err = 1'bx; s_cnt = 0; r_cnt = 0;
        for (int n = 0; n <= 12 && act_lat < 0; n++) begin
            @(posedge CLK); #1;
            if (n == 0) begin
                for (int k = 0; k < 4; k++) if (gnt_o == (4'b0001 << k)) act_w = k;
                chk("grant", 32'(gnt_o), 32'(w_oh));
                chk("busy_on_grant", 32'(busy_o), 32'(1));
                if (sel) op_b = 4'($urandom); else op_a = 4'($urandom);
                if (drop) begin
                    if (sel) req_b[2'(w)] = 1'b0; else req_a[2'(w)] = 1'b0;
                end
            end
            if (s_o) s_cnt++;
            if (r_o) r_cnt++;
            if (ack_o != 4'b0) begin
                act_lat = n;
                act_err = err_o;
                chk("ack_onehot", 32'(ack_o), 32'(w_oh));
                chk("err", 32'(err_o), 32'(err_exp));
                chk("gnt_during_ack", 32'(gnt_o), 32'(w_oh));
            end
        end
        if (sel) req_b = 4'b0; else req_a = 4'b0;
        chk("ack_latency", 32'(act_lat), 32'(lat_exp));
        chk("s_pulse_cycles", 32'(s_cnt), 32'((!skip && tgt) ? p : 0));
        chk("r_pulse_cycles", 32'(r_cnt), 32'((!skip && !tgt) ? p : 0));
        @(posedge CLK); #1;
        chk("release", 32'({gnt_o, ack_o, err_o, busy_o}), 32'(0));
        stuck[sel] = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        int   aw, al;
        logic ae;
        RST = 1'b0; req_a = 4'b0; op_a = 4'b0; req_b = 4'b0; op_b = 4'b0;
        pre_en = 2'b0; pre_val = 2'b0; stuck = 2'b0; cur = 1'b0;
        m_ptr[0] = 0; m_ptr[1] = 0;

        //                sel req      op       pre pv stk drop  w lat err
        tbl[0]  = '{1'b0, 4'b1111, 4'b0000, 1, 1, 0, 0,  0, 4, 0};
        tbl[1]  = '{1'b0, 4'b1111, 4'b1010, 0, 0, 0, 0,  1, 4, 0};
        tbl[2]  = '{1'b0, 4'b1111, 4'b0101, 0, 0, 0, 0,  2, 0, 0};
        tbl[3]  = '{1'b0, 4'b1111, 4'b0101, 0, 0, 0, 0,  3, 4, 0};
        tbl[4]  = '{1'b0, 4'b1111, 4'b1010, 0, 0, 0, 0,  0, 0, 0};
        tbl[5]  = '{1'b0, 4'b0100, 4'b0100, 1, 0, 0, 1,  2, 4, 0};
        tbl[6]  = '{1'b0, 4'b0010, 4'b0000, 1, 0, 0, 0,  1, 0, 0};
        tbl[7]  = '{1'b0, 4'b0001, 4'b0001, 1, 0, 1, 0,  0, 4, 1};
        tbl[8]  = '{1'b0, 4'b0001, 4'b0001, 1, 0, 0, 0,  0, 4, 0};
        tbl[9]  = '{1'b1, 4'b0001, 4'b0001, 1, 0, 0, 0,  0, 2, 0};
        tbl[10] = '{1'b1, 4'b1001, 4'b0000, 0, 0, 0, 0,  3, 2, 0};
        tbl[11] = '{1'b1, 4'b0110, 4'b0110, 1, 0, 1, 0,  1, 2, 1};

        #1 RST = 1'b1;
        #1;
        chk("reset_state_a", 32'({gnt_a, ack_a, err_a, busy_a, s_a, r_a}), 32'(0));
        chk("reset_state_b", 32'({gnt_b, ack_b, err_b, busy_b, s_b, r_b}), 32'(0));
        @(negedge CLK);
        RST = 1'b0;
        preset(1'b0, 1'b0);
        preset(1'b1, 1'b0);

        // Reset in the middle of a set pulse
        cur = 1'b0; req_a = 4'b0100; op_a = 4'b0100;
        @(posedge CLK); #1;
        chk("pre_reset_s_out", 32'(s_a), 32'(1));
        #2 RST = 1'b1;
        #1;
        chk("async_reset_clear", 32'({s_a, r_a, gnt_a, busy_a, ack_a}), 32'(0));
        req_a = 4'b0;
        @(negedge CLK);
        @(posedge CLK); #1;
        chk("no_ack_in_reset", 32'({ack_a, err_a}), 32'(0));
        @(negedge CLK);
        RST = 1'b0;
        m_ptr[0] = 0; m_ptr[1] = 0;

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].pre) preset(tbl[i].sel, tbl[i].pre_val);
            run_op(tbl[i].sel, tbl[i].req, tbl[i].op, tbl[i].stuck, tbl[i].drop, aw, al, ae);
            chk($sformatf("vec%0d_winner", i), 32'(aw), 32'(tbl[i].exp_w));
            chk($sformatf("vec%0d_latency", i), 32'(al), 32'(tbl[i].exp_lat));
            chk($sformatf("vec%0d_err", i), 32'(ae), 32'(tbl[i].exp_err));
        end

        for (int i = 0; i < 40; i++) begin
            bit sel;
            sel = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) preset(sel, 1'($urandom));
            run_op(sel, 4'($urandom_range(1, 15)), 4'($urandom),
                   ($urandom_range(0, 7) == 0), 1'($urandom), aw, al, ae);
        end

        chk("sr_overlap_events", 32'(ovl_cnt), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/srlatch_arbiter.md
Name: srlatch_arbiter

Overview:
- Shares one external SR latch between NREQ requesters.
- Each requester asks to set or reset the latch. The block grants one requester at a time, round-robin.
- For each grant it drives a timed S or R pulse, waits for the latch to settle, reads Q back and returns ACK, or ACK plus ERR on mismatch.
- It guarantees S and R are never high together, which is the forbidden latch input.

Parameters:
- NREQ, 4, number of requesters (2..8).
- PULSE_CYC, 2, cycles S_OUT/R_OUT is held high per operation (>=1).
- SETTLE_CYC, 1, idle cycles after the pulse before Q is sampled (>=0).

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- REQ  input  NREQ  per-requester request; held high until ACK is seen.
- OP  input  NREQ  per-requester operation: 1 = set (target Q=1), 0 = reset (target Q=0). Valid while REQ is high.
- GNT  output  NREQ  one-hot grant; high from grant until the end of the ACK cycle.
- ACK  output  NREQ  one-hot, one-cycle completion pulse.
- ERR  output  1  one-cycle, coincident with ACK; Q readback did not equal target.
- BUSY  output  1  high in any state other than IDLE.
- S_OUT  output  1  latch set drive.
- R_OUT  output  1  latch reset drive.
- Q_IN  input  1  latch Q output; treated as synchronous to CLK.

Behaviour:
- Reset (async, RST=1): state=IDLE; GNT, ACK, ERR, BUSY, S_OUT, R_OUT = 0; round-robin pointer=0; counters=0. Outputs are cleared immediately, not at the next edge.
- All outputs are registered.
- FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
- IDLE: at an edge with any REQ high, select winner i: first REQ[k] high scanning k = ptr, ptr+1, ... modulo NREQ. Latch target=OP[i]; GNT[i]=1; ptr<=(i+1) mod NREQ.
  - If Q_IN already equals target at that edge, go to DONE with no pulse (skip).
  - Otherwise go to DRIVE. S_OUT=target and R_OUT=~target take effect at the same edge.
- DRIVE: hold the pulse for exactly PULSE_CYC cycles, then clear S_OUT/R_OUT.
  - Next state is SETTLE if SETTLE_CYC>0, else CHECK.
- SETTLE: both drives 0 for exactly SETTLE_CYC cycles, then CHECK.
- CHECK: one cycle, both drives 0. At its ending edge, sample Q_IN. Go to DONE with ACK[i]=1 and ERR=(Q_IN!=target).
- DONE: one cycle with ACK[i], GNT[i] and ERR visible. No arbitration here. Next edge returns to IDLE and clears GNT/ACK/ERR.
- Requester handshake: drop REQ in the cycle after ACK. A REQ still high in the following IDLE cycle is treated as a new request.
- Latency, non-skip: ACK is high in the cycle after edge e0+PULSE_CYC+SETTLE_CYC+1, where e0 is the IDLE edge that sampled REQ. Defaults: ACK after edge e0+4.
- Latency, skip: ACK is high in the cycle after e0.
- Invariant: S_OUT&R_OUT==0 in every cycle, including across reset.
- REQ[i] dropping mid-operation does not abort it; the operation completes and ACK is still issued.
- OP changes after grant are ignored.
- A REQ from a non-granted requester during BUSY waits; no loss, no grant until the next IDLE.
- Reset mid-operation: drives drop immediately, the in-flight ACK is never issued, and ptr returns to 0.
- Counters are sized $clog2(max(PULSE_CYC,SETTLE_CYC)+1) bits and count down to 1. No wrap beyond the terminal count.

Test Plan:
- Reset: assert RST mid-DRIVE with S_OUT=1 -> S_OUT, R_OUT, GNT, BUSY go 0 without a clock edge; after release, first grant goes to lowest-index requester.
- Single set, defaults, Q_IN model = ideal latch with 1-cycle delay: REQ[2]=1, OP[2]=1 at e0 -> S_OUT high exactly 2 cycles, ACK[2]=1 after e0+4, ERR=0, GNT[2] drops after e0+5.
- Skip: Q_IN=0, REQ[1]=1, OP[1]=0 -> ACK[1] in the cycle after e0, S_OUT=R_OUT=0 throughout, ERR=0.
- Round-robin: REQ=4'b1111 held, alternating OPs -> grant order 0,1,2,3,0; no requester is granted twice before all others.
- Fault: Q_IN tied 0, REQ[0] with OP=1 -> full pulse sequence, then ACK[0]=1 with ERR=1; next request is unaffected.
- Parameter sweep PULSE_CYC=1, SETTLE_CYC=0 -> ACK after e0+2. Assertion S_OUT&R_OUT==0 holds in all runs.
